// File: rtl/t03_sprite_loader.sv
`default_nettype none
// ============================================================================
//  Module      : t03_sprite_loader
//  Description : Loads one 15x20 8-bpp player sprite from byte-wide memory
//                over a req/ack handshake into a shadow buffer. The shadow
//                buffer is copied to the visible sprite bus on a frame-start
//                pulse, so the displayed sprite never tears mid-frame.
//  Revision    : 1.0  initial release
// ============================================================================
module t03_sprite_loader #(
  parameter int PIX_W  = 8,
  parameter int SPR_W  = 15,
  parameter int SPR_H  = 20,
  parameter int ADDR_W = 16,
  localparam int NPIX  = SPR_W * SPR_H
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_load_start,
  input  logic [ADDR_W-1:0]       i_base_addr,
  output logic                    o_mem_req,
  output logic [ADDR_W-1:0]       o_mem_addr,
  input  logic                    i_mem_ack,
  input  logic [PIX_W-1:0]        i_mem_rdata,
  input  logic                    i_frame_start,
  output logic [NPIX*PIX_W-1:0]   o_player,
  output logic                    o_busy,
  output logic                    o_load_done
);

  localparam int BUS_W  = NPIX * PIX_W;
  localparam int CNT_W  = $clog2(NPIX);
  localparam int SLOT_W = $clog2(BUS_W);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_SWAP_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_req;
  logic [BUS_W-1:0]    r_shadow;
  logic [BUS_W-1:0]    r_player;
  logic                r_done;

  logic                w_ack;
  logic                w_last;
  logic                w_swap;
  logic [SLOT_W-1:0]   w_slot_lsb;

  // An ack only counts while a request is outstanding; stray acks are dropped.
  assign w_ack  = i_mem_ack & r_req;
  assign w_last = (r_cnt == CNT_W'(NPIX - 1));
  assign w_swap = (r_state == S_SWAP_WAIT) && i_frame_start;

  // Pixel k lands in slot NPIX-1-k so the top-left pixel sits in the MSBs.
  assign w_slot_lsb = SLOT_W'((NPIX - 1 - int'(r_cnt)) * PIX_W);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; frame_start only matters once the shadow is complete.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (i_load_start)       w_state_nxt = S_FETCH;
      S_FETCH:     if (w_ack && w_last)    w_state_nxt = S_SWAP_WAIT;
      S_SWAP_WAIT: if (i_frame_start)      w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  // Request, address and pixel counter: one outstanding read, address held until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load_start) begin
            r_req  <= 1'b1;
            r_addr <= i_base_addr;
            r_cnt  <= '0;
          end
        end
        S_FETCH: begin
          if (w_ack) begin
            if (w_last) begin
              r_req <= 1'b0;
            end else begin
              r_cnt  <= r_cnt + CNT_W'(1);
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shadow buffer capture of each returned pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_ack) begin
      r_shadow[w_slot_lsb +: PIX_W] <= i_mem_rdata;
    end
  end

  // Visible bus changes only at the swap edge; done pulses in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_player <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_swap;
      if (w_swap) begin
        r_player <= r_shadow;
      end
    end
  end

  assign o_mem_req   = r_req;
  assign o_mem_addr  = r_addr;
  assign o_player    = r_player;
  assign o_busy      = (r_state != S_IDLE);
  assign o_load_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_t03_sprite_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t03_sprite_loader
//  Description : Scoreboard bench for t03_sprite_loader. Stimulus pushes the
//                expected read addresses and final image; a monitor pops and
//                compares on every accepted read and on every load_done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_t03_sprite_loader;

  localparam int PIX_W  = 8;
  localparam int NPIX   = 300;
  localparam int ADDR_W = 16;
  localparam int BUS_W  = NPIX * PIX_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_load_start;
  logic [ADDR_W-1:0]   i_base_addr;
  logic                o_mem_req;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic                i_mem_ack;
  logic [PIX_W-1:0]    i_mem_rdata;
  logic                i_frame_start;
  logic [BUS_W-1:0]    o_player;
  logic                o_busy;
  logic                o_load_done;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [BUS_W-1:0]  exp_img[$];

  int max_delay = 0;
  bit spurious  = 1'b0;
  int done_cnt  = 0;

  always #5 clk = ~clk;

  t03_sprite_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_start (i_load_start),
    .i_base_addr  (i_base_addr),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .i_frame_start(i_frame_start),
    .o_player     (o_player),
    .o_busy       (o_busy),
    .o_load_done  (o_load_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected image: pixel k = low byte of (base+k), top-left pixel in the MSBs.
  function automatic logic [BUS_W-1:0] build_img(input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] a;
    build_img = '0;
    for (int k = 0; k < NPIX; k++) begin
      a = base + ADDR_W'(k);
      build_img[(NPIX-1-k)*PIX_W +: PIX_W] = a[7:0];
    end
  endfunction

  // Memory model: mem[a] = a[7:0], random ack delay, address-stability check.
  initial begin : responder
    bit                in_txn;
    int                wait_left;
    logic [ADDR_W-1:0] held;
    in_txn = 1'b0;
    wait_left = 0;
    held = '0;
    i_mem_ack = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      i_mem_ack = 1'b0;
      if (!rst_n) begin
        in_txn = 1'b0;
      end else if (!o_mem_req) begin
        in_txn = 1'b0;
        if (spurious) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = 8'h5A;
        end
      end else begin
        if (!in_txn) begin
          in_txn = 1'b1;
          held = o_mem_addr;
          wait_left = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
        end else begin
          check("addr_stable", 32'(o_mem_addr), 32'(held));
        end
        if (wait_left == 0) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = o_mem_addr[7:0];
          in_txn = 1'b0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT accepts a read or signals load_done.
  initial begin : monitor
    logic             prev_done;
    logic [BUS_W-1:0] img;
    int               bad;
    logic [7:0]       bad_act;
    logic [7:0]       bad_exp;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_done = 1'b0;
      end else begin
        if (o_mem_req && i_mem_ack) begin
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read actual=%0h required=none", o_mem_addr);
          end else begin
            check("read_addr", 32'(o_mem_addr), 32'(exp_addr.pop_front()));
          end
        end
        if (prev_done) check("load_done_width", 32'(o_load_done), 32'd0);
        if (o_load_done) begin
          done_cnt++;
          check("busy_at_done", 32'(o_busy), 32'd0);
          checks++;
          if (exp_img.size() == 0) begin
            errors++;
            $display("FAIL unexpected_load_done actual=1 required=0");
          end else begin
            img = exp_img.pop_front();
            bad = -1;
            bad_act = '0;
            bad_exp = '0;
            for (int k = 0; k < NPIX; k++) begin
              if (bad < 0 && o_player[(NPIX-1-k)*PIX_W +: PIX_W] !== img[(NPIX-1-k)*PIX_W +: PIX_W]) begin
                bad = k;
                bad_act = o_player[(NPIX-1-k)*PIX_W +: PIX_W];
                bad_exp = img[(NPIX-1-k)*PIX_W +: PIX_W];
              end
            end
            if (bad >= 0) begin
              errors++;
              $display("FAIL player_image pixel %0d actual=%0h required=%0h", bad, bad_act, bad_exp);
            end
          end
        end
        prev_done = o_load_done;
      end
    end
  end

  // Called just after a negedge; returns at the negedge after the load is accepted.
  task automatic start_load(input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < NPIX; k++) begin
      a = base + ADDR_W'(k);
      exp_addr.push_back(a);
    end
    exp_img.push_back(build_img(base));
    i_base_addr = base;
    i_load_start = 1'b1;
    @(negedge clk);
    i_load_start = 1'b0;
    i_base_addr = 16'hBEEF;
  endtask

  task automatic wait_fetch(output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    while (o_mem_req && n < 4000) begin
      n++;
      if (!o_busy) busy_low++;
      @(negedge clk);
    end
    if (o_mem_req) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout actual=req_high required=req_low");
    end
  endtask

  task automatic pulse_frame();
    int d0;
    d0 = done_cnt;
    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
    repeat (2) @(negedge clk);
    check("load_done_count", 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int bl;
    int d0;
    logic [BUS_W-1:0] prev_img;
    i_load_start = 1'b0;
    i_base_addr = '0;
    i_frame_start = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    check("rst_player_zero", 32'(o_player == '0), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_load_done", 32'(o_load_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: zero-wait load from 0x100
    max_delay = 0;
    start_load(16'h0100);
    wait_fetch(n, bl);
    check("t1_req_cycles", 32'(n), 32'd300);
    check("t1_busy_low", 32'(bl), 32'd0);
    check("t1_busy_swapwait", 32'(o_busy), 32'd1);
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    spurious = 1'b0;
    check("t1_player_before_swap", 32'(o_player == '0), 32'd1);
    pulse_frame();
    check("t1_pix0", 32'(o_player[2399:2392]), 32'h00);
    check("t1_pix299", 32'(o_player[7:0]), 32'h2B);

    // 2: random 0-3 cycle ack delays, same image
    max_delay = 3;
    start_load(16'h0100);
    wait_fetch(n, bl);
    check("t2_busy_low", 32'(bl), 32'd0);
    check("t2_busy_swapwait", 32'(o_busy), 32'd1);
    pulse_frame();
    check("t2_busy_after", 32'(o_busy), 32'd0);

    // 3: address wrap from 0xFF80
    max_delay = 1;
    start_load(16'hFF80);
    wait_fetch(n, bl);
    pulse_frame();
    check("t3_pix0", 32'(o_player[2399:2392]), 32'h80);
    check("t3_pix127", 32'(o_player[1383:1376]), 32'hFF);
    check("t3_pix128", 32'(o_player[1375:1368]), 32'h00);
    check("t3_pix299", 32'(o_player[7:0]), 32'hAB);
    prev_img = build_img(16'hFF80);

    // 4: frame_start on the final ack edge must not swap
    max_delay = 0;
    d0 = done_cnt;
    start_load(16'h0040);
    repeat (299) @(negedge clk);
    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_req_low", 32'(o_mem_req), 32'd0);
    check("t4_busy", 32'(o_busy), 32'd1);
    check("t4_player_hold", 32'(o_player == prev_img), 32'd1);
    check("t4_no_done", 32'(done_cnt), 32'(d0));
    pulse_frame();

    // 5: second load_start mid-load is ignored
    max_delay = 2;
    start_load(16'h0300);
    repeat (100) @(negedge clk);
    check("t5_busy_mid", 32'(o_busy), 32'd1);
    i_base_addr = 16'h0200;
    i_load_start = 1'b1;
    @(negedge clk);
    i_load_start = 1'b0;
    i_base_addr = 16'hBEEF;
    wait_fetch(n, bl);
    check("t5_busy_low", 32'(bl), 32'd0);
    pulse_frame();

    // 6: reset mid-load clears everything at once, then a fresh load
    max_delay = 0;
    start_load(16'h0100);
    repeat (149) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_req_async", 32'(o_mem_req), 32'd0);
    check("t6_addr_async", 32'(o_mem_addr), 32'd0);
    check("t6_player_zero", 32'(o_player == '0), 32'd1);
    check("t6_busy_async", 32'(o_busy), 32'd0);
    exp_addr.delete();
    exp_img.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_load(16'h0100);
    wait_fetch(n, bl);
    check("t6_req_cycles", 32'(n), 32'd300);
    pulse_frame();
    check("t6_pix299", 32'(o_player[7:0]), 32'h2B);

    repeat (3) @(negedge clk);
    check("left_addr_expect", 32'(exp_addr.size()), 32'd0);
    check("left_img_expect", 32'(exp_img.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
